// File: rtl/encoder_4to2_seq_pkg.sv
// Shared definitions for the 4-to-2 sequential encoder.
//   CODE_W / REQ_W : widths of an encoded index and of the request vector
//   code_t / req_t : matching types
//   prio_enc()     : highest-set-bit encoder, priority 3 > 2 > 1 > 0
package encoder_pkg;

  localparam int unsigned CODE_W = 2;
  localparam int unsigned REQ_W  = 4;

  typedef logic [CODE_W-1:0] code_t;
  typedef logic [REQ_W-1:0]  req_t;

  // Returns 0 for an all-zero vector; callers qualify with |r.
  function automatic code_t prio_enc(input req_t r);
    code_t c;
    c = '0;
    if (r[3])      c = code_t'(3);
    else if (r[2]) c = code_t'(2);
    else if (r[1]) c = code_t'(1);
    else           c = code_t'(0);
    return c;
  endfunction

endpackage

// File: rtl/encoder_4to2_seq_if.sv
// Request/result bundle of the encoder.
//   en        : enable for new request edges
//   in        : level request lines
//   out_ready : downstream accept
//   out       : code at queue head
//   out_valid : out holds a valid code
//   drop      : one-cycle pulse, a request edge was lost
//   busy      : requests pending or queue non-empty
// master = requester/consumer side, slave = encoder side.
interface encoder_4to2_seq_if;
  import encoder_pkg::*;

  logic  en;
  req_t  in;
  logic  out_ready;
  code_t out;
  logic  out_valid;
  logic  drop;
  logic  busy;

  modport master (
    output en, in, out_ready,
    input  out, out_valid, drop, busy
  );

  modport slave (
    input  en, in, out_ready,
    output out, out_valid, drop, busy
  );
endinterface

// File: rtl/encoder_4to2_seq_sync_fifo.sv
// Synchronous FIFO for encoded indices.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write request and data (ignored when full without a pop)
//   pop, dout  : read request and head data (dout is 0 while empty)
//   full, empty, count : occupancy status
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/encoder_4to2_seq.sv
// Sequential 4-to-2 priority encoder with edge-triggered requests.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : encoder_4to2_seq_if.slave (en, in, out_ready -> out,
//                out_valid, drop, busy)
// Rising edges on in (while en) latch a pending bit; each cycle the highest
// pending bit is granted into an output FIFO of DEPTH entries.
module encoder_4to2_seq
  import encoder_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  encoder_4to2_seq_if.slave  bus
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  req_t          in_q, in_d;
  req_t          pending_q, pending_d;
  logic          drop_q, drop_d;
  req_t          rise, grant_mask;
  code_t         grant_code, fifo_dout;
  logic          push, pop, can_push;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;

  always_comb begin
    in_d       = bus.in;
    rise       = bus.in & ~in_q & {REQ_W{bus.en}};
    pop        = !fifo_empty && bus.out_ready;
    // A full queue still accepts when its head leaves in the same cycle.
    can_push   = !fifo_full || pop;
    push       = can_push && (|pending_q);
    grant_code = prio_enc(pending_q);
    grant_mask = push ? (req_t'(1) << grant_code) : '0;
    // New rise wins over the clear of a bit granted this cycle.
    pending_d  = (pending_q & ~grant_mask) | rise;
    drop_d     = |(rise & pending_q & ~grant_mask);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q      <= '0;
      pending_q <= '0;
      drop_q    <= 1'b0;
    end else begin
      in_q      <= in_d;
      pending_q <= pending_d;
      drop_q    <= drop_d;
    end
  end

  sync_fifo #(
    .WIDTH (CODE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (grant_code),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.out       = fifo_dout;
  assign bus.out_valid = (fifo_count != '0);
  assign bus.drop      = drop_q;
  assign bus.busy      = (|pending_q) | bus.out_valid;

endmodule

// File: doc/encoder_4to2_seq.md
ENCODER_4TO2_SEQ -- requirements
Module: encoder_4to2_seq

Interface
REQ-001 SHALL have parameter DEPTH, default 2, output FIFO depth in entries (power of two, 2..8).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port en  input  1  enable; when 0, new request edges are ignored.
REQ-005 SHALL have port in  input  4  level request lines; bit i requests code i.
REQ-006 SHALL have port out_ready  input  1  downstream accepts out when high with out_valid.
REQ-007 SHALL have port out  output  2  encoded request index at FIFO head.
REQ-008 SHALL have port out_valid  output  1  out holds a valid code.
REQ-009 SHALL have port drop  output  1  one-cycle pulse: a request edge was lost.
REQ-010 SHALL have port busy  output  1  high while any request is pending or FIFO is non-empty.

Function
REQ-011 SHALL register in into in_q every cycle; rise = in & ~in_q & {4{en}}.
REQ-012 SHALL set pending[i] on rise[i]; an edge sampled at edge E0 sets pending at E0.
REQ-013 SHALL each cycle grant the highest set pending bit (priority 3 > 2 > 1 > 0) when the FIFO can accept a push.
REQ-014 SHALL treat the FIFO as able to accept when count < DEPTH, or when count == DEPTH and a pop occurs in the same cycle.
REQ-015 SHALL, on a grant, push the 2-bit index and clear that pending bit at the same edge; at most one grant per cycle.
REQ-016 SHALL keep a bit pending if it is granted and has a new rise in the same cycle (set wins).
REQ-017 SHALL pulse drop for one cycle when rise[i] hits an already-pending bit i that is not granted that cycle; pending stays 1.
REQ-018 SHALL deliver latency of 2 edges from a sampled edge to out_valid (E0 pending, E1 push, out_valid after E1) when FIFO empty and no higher-priority bits pending.
REQ-019 SHALL pop the FIFO head on out_valid && out_ready; out_valid = (count != 0).
REQ-020 SHALL hold out stable while out_valid && !out_ready.
REQ-021 SHALL, when en is low, keep pending and FIFO contents and continue granting and draining.
REQ-022 SHALL wrap FIFO read/write pointers modulo DEPTH; count never exceeds DEPTH or underflows.
REQ-023 SHALL drive busy = (|pending) | out_valid.

Reset
REQ-024 SHALL, on rst_n low (asynchronous), clear in_q, pending, FIFO pointers and count; out = 0, out_valid = 0, drop = 0, busy = 0.
REQ-025 SHALL discard all pending requests and queued codes on reset mid-operation.
REQ-026 SHALL, since in_q resets to 0, treat any in bit already high at the first edge after reset release as a rise.

Structure
REQ-027 SHALL place code width (2), request width (4) and the priority-encode function in shared package encoder_pkg.
REQ-028 SHALL implement the output queue as sub-module sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count).
REQ-029 SHALL keep edge detection, pending register and grant logic in encoder_4to2_seq.

Verification
REQ-030 SHALL cover single request: en=1, in 0000->0100 -> out=2'b10, out_valid high 2 edges after sampling, drop=0.
REQ-031 SHALL cover simultaneous edges: in 0000->1011, out_ready=1 -> codes 3,1,0 in consecutive cycles, busy falls after last pop.
REQ-032 SHALL cover backpressure: DEPTH=2, out_ready=0, edges on bits 0,1,2 -> FIFO holds 1,2 (or priority order of grant), bit pending, out stable; raising out_ready drains all three.
REQ-033 SHALL cover drop: out_ready=0, FIFO full, pulse in[1] twice -> drop=1 exactly one cycle on second edge.
REQ-034 SHALL cover enable gating: en=0, in 0000->1111 -> out_valid stays 0; en=1 with in held -> no codes (no new edge).
REQ-035 SHALL cover reset mid-operation: pending and FIFO non-empty, rst_n low -> out_valid=0, busy=0 immediately; in=0001 held through release -> code 0 produced.
